updown_count_monitor: RTL and testbench

Receive-side checker for the 4-bit up/down counter: samples the counter's `count` output every enabled clock, recovers the counting direction without access to the mode input, locks once steps are consistent, and flags illegal jumps, direction reversals and wrap-arounds. It sits beside the counter in simulation and FPGA debug builds as the reader of its count bus.

---
 rtl/updown_mon_pkg.sv | 19 +
 rtl/count_step_classify.sv | 41 ++++
 rtl/updown_count_monitor.sv | 168 ++++++++++++++++
 tb/tb_updown_count_monitor.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/updown_mon_pkg.sv
// Shared types for the up/down count monitor: tracking state and step classes.
package updown_mon_pkg;

    // Tracking state of the monitor.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,   // no previous sample stored yet
        S_ACQ   = 2'd1,   // acquiring a consistent run of +/-1 steps
        S_LOCK  = 2'd2    // locked onto a consistent sequence
    } state_t;

    // Classification of one sample against the previous one.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0, // same value
        STEP_UP   = 2'd1, // +1 modulo 2^WIDTH
        STEP_DOWN = 2'd2, // -1 modulo 2^WIDTH
        STEP_JUMP = 2'd3  // any other difference
    } step_t;

endpackage

// File: rtl/count_step_classify.sv
// Combinational step classifier: compares the new count with the stored one
// and reports the step class plus whether the step crossed max<->0.
module count_step_classify
    import updown_mon_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] count,
    output step_t            step,
    output logic             crosses
);

    localparam logic [WIDTH-1:0] VAL_ZERO = '0;
    localparam logic [WIDTH-1:0] VAL_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] VAL_MAX  = '1;

    logic [WIDTH-1:0] delta;

    // Modular difference; wrap-around of the subtraction is intentional.
    assign delta = count - prev;

    // Map the difference onto a step class; +1 takes priority for tiny widths.
    always_comb begin
        step = STEP_JUMP;
        if (delta == VAL_ZERO) begin
            step = STEP_HOLD;
        end else if (delta == VAL_ONE) begin
            step = STEP_UP;
        end else if (delta == VAL_MAX) begin
            step = STEP_DOWN;
        end
    end

    // A crossing is exactly max->0 or 0->max, regardless of direction state.
    always_comb begin
        crosses = ((prev == VAL_MAX) && (count == VAL_ZERO)) ||
                  ((prev == VAL_ZERO) && (count == VAL_MAX));
    end

endmodule

// File: rtl/updown_count_monitor.sv
// Receive-side checker for an up/down counter: recovers direction from the
// observed count, locks after LOCK_N consistent steps and flags anomalies.
module updown_count_monitor
    import updown_mon_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             locked,
    output logic             step_err,
    output logic             dir_change,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int               RUN_W    = $clog2(LOCK_N + 1);
    localparam logic [RUN_W-1:0] RUN_ZERO = '0;
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_N);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_N - 1);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] prev_reg;
    logic [RUN_W-1:0] run_reg, run_next;
    logic             dir_reg, dir_next;
    logic             locked_reg, locked_next;
    logic             step_err_reg, step_err_next;
    logic             dir_change_reg, dir_change_next;
    logic             wrap_reg, wrap_next;
    logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

    step_t            step;
    logic             crosses;
    logic             step_dir;

    count_step_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .prev    (prev_reg),
        .count   (count),
        .step    (step),
        .crosses (crosses)
    );

    assign step_dir = (step == STEP_UP);

    // Next-state and next-output logic; everything holds and pulses drop when en = 0.
    always_comb begin
        state_next      = state_reg;
        run_next        = run_reg;
        dir_next        = dir_reg;
        locked_next     = locked_reg;
        err_cnt_next    = err_cnt_reg;
        step_err_next   = 1'b0;
        dir_change_next = 1'b0;
        wrap_next       = 1'b0;

        if (en) begin
            case (state_reg)
                S_EMPTY: begin
                    state_next  = S_ACQ;
                    run_next    = RUN_ZERO;
                    locked_next = 1'b0;
                end

                S_ACQ: begin
                    case (step)
                        STEP_UP, STEP_DOWN: begin
                            dir_next = step_dir;
                            if ((run_reg == RUN_ZERO) || (step_dir == dir_reg)) begin
                                // Extending the run; lock once it reaches LOCK_N.
                                if (run_reg >= RUN_LAST) begin
                                    run_next    = RUN_MAX;
                                    state_next  = S_LOCK;
                                    locked_next = 1'b1;
                                end else begin
                                    run_next = run_reg + RUN_ONE;
                                end
                            end else if (LOCK_N == 1) begin
                                // A reversal restarts the run at 1, which is enough here.
                                run_next    = RUN_MAX;
                                state_next  = S_LOCK;
                                locked_next = 1'b1;
                            end else begin
                                run_next = RUN_ONE;
                            end
                        end
                        STEP_JUMP: begin
                            run_next = RUN_ZERO;
                        end
                        default: begin
                        end
                    endcase
                end

                S_LOCK: begin
                    case (step)
                        STEP_UP, STEP_DOWN: begin
                            dir_change_next = (step_dir != dir_reg);
                            dir_next        = step_dir;
                            wrap_next       = crosses;
                        end
                        STEP_JUMP: begin
                            step_err_next = 1'b1;
                            if (err_cnt_reg != ERR_MAX) begin
                                err_cnt_next = err_cnt_reg + ERR_ONE;
                            end
                            state_next  = S_ACQ;
                            run_next    = RUN_ZERO;
                            locked_next = 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end

                default: begin
                    state_next  = S_EMPTY;
                    run_next    = RUN_ZERO;
                    locked_next = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= S_EMPTY;
            prev_reg       <= '0;
            run_reg        <= RUN_ZERO;
            dir_reg        <= 1'b1;
            locked_reg     <= 1'b0;
            step_err_reg   <= 1'b0;
            dir_change_reg <= 1'b0;
            wrap_reg       <= 1'b0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            run_reg        <= run_next;
            dir_reg        <= dir_next;
            locked_reg     <= locked_next;
            step_err_reg   <= step_err_next;
            dir_change_reg <= dir_change_next;
            wrap_reg       <= wrap_next;
            err_cnt_reg    <= err_cnt_next;
            if (en) begin
                prev_reg <= count;
            end
        end
    end

    assign dir        = dir_reg;
    assign locked     = locked_reg;
    assign step_err   = step_err_reg;
    assign dir_change = dir_change_reg;
    assign wrap       = wrap_reg;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_updown_count_monitor.sv
// Directed bench for updown_count_monitor: hand-computed expectations per sample.
module tb_updown_count_monitor;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] count;
    logic       dir;
    logic       locked;
    logic       step_err;
    logic       dir_change;
    logic       wrap;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    updown_count_monitor #(
        .WIDTH  (4),
        .LOCK_N (2),
        .ERR_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .count      (count),
        .dir        (dir),
        .locked     (locked),
        .step_err   (step_err),
        .dir_change (dir_change),
        .wrap       (wrap),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_out(input string tag, input logic d, input logic l,
                              input logic se, input logic dc, input logic w,
                              input logic [7:0] ec);
        check({tag, ".dir"},        32'(dir),        32'(d));
        check({tag, ".locked"},     32'(locked),     32'(l));
        check({tag, ".step_err"},   32'(step_err),   32'(se));
        check({tag, ".dir_change"}, 32'(dir_change), 32'(dc));
        check({tag, ".wrap"},       32'(wrap),       32'(w));
        check({tag, ".err_cnt"},    32'(err_cnt),    32'(ec));
    endtask

    // One sampled transaction: drive on the falling edge, observe 1 ns after the rising edge.
    task automatic sample(input logic [3:0] c, input logic e);
        @(negedge clk);
        en    = e;
        count = c;
        @(posedge clk);
        #1;
        $display("t=%0t en=%0d count=%0d -> dir=%0d locked=%0d step_err=%0d dir_change=%0d wrap=%0d err_cnt=%0d",
                 $time, e, c, dir, locked, step_err, dir_change, wrap, err_cnt);
    endtask

    initial begin
        logic [3:0] base;
        int         exp_err;

        rst   = 1'b0;
        en    = 1'b0;
        count = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b1;

        // Acquire upward: lock after the sample of 2.
        sample(4'd0, 1'b1); expect_out("acq0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        sample(4'd1, 1'b1); expect_out("acq1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        sample(4'd2, 1'b1); expect_out("acq2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        sample(4'd3, 1'b1); expect_out("acq3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        for (int v = 4; v <= 15; v++) begin
            sample(4'(v), 1'b1);
            expect_out("up_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        end

        // Upward wrap 15 -> 0, then reversal and downward wrap 0 -> 15.
        sample(4'd0,  1'b1); expect_out("wrap_up",     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        sample(4'd1,  1'b1); expect_out("after_wrap",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        sample(4'd0,  1'b1); expect_out("rev_down",    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        sample(4'd15, 1'b1); expect_out("wrap_down",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);

        for (int v = 14; v >= 6; v--) begin
            sample(4'(v), 1'b1);
            expect_out("down_run", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        end

        // Up to 7, then back to 6: two reversals while locked.
        sample(4'd7, 1'b1); expect_out("rev_up7",   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        sample(4'd6, 1'b1); expect_out("rev_down6", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        sample(4'd5, 1'b1); expect_out("down5",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        // Illegal jump 5 -> 9, then relock on 10, 11.
        sample(4'd9,  1'b1); expect_out("jump9",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        sample(4'd10, 1'b1); expect_out("reacq10", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        sample(4'd11, 1'b1); expect_out("relock11", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);

        for (int v = 12; v <= 15; v++) begin
            sample(4'(v), 1'b1);
            expect_out("up_run2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        end
        sample(4'd0, 1'b1); expect_out("wrap_up2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
        sample(4'd1, 1'b1); expect_out("up1",      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        sample(4'd2, 1'b1); expect_out("up2",      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        sample(4'd3, 1'b1); expect_out("up3",      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);

        // Holds, then an enable gap with a stray count, then resume at 4.
        sample(4'd3,  1'b1); expect_out("hold_a", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        sample(4'd3,  1'b1); expect_out("hold_b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        sample(4'd12, 1'b0); expect_out("gap_a",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        sample(4'd12, 1'b0); expect_out("gap_b",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        sample(4'd4,  1'b1); expect_out("resume4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);

        // Alternating jumps 8/0 with a two-step relock after each; counter saturates at 255.
        for (int i = 0; i < 260; i++) begin
            base    = (i % 2 == 1) ? 4'd0 : 4'd8;
            exp_err = (i + 2 > 255) ? 255 : i + 2;
            sample(base, 1'b1);
            expect_out("sat_jump", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(exp_err));
            sample(base + 4'd1, 1'b1);
            expect_out("sat_acq", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'(exp_err));
            sample(base + 4'd2, 1'b1);
            expect_out("sat_lock", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'(exp_err));
        end
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);

        // One-edge reset with en high: everything returns to reset values.
        @(negedge clk);
        rst   = 1'b0;
        en    = 1'b1;
        count = 4'd7;
        @(posedge clk);
        #1;
        $display("t=%0t reset pulse -> dir=%0d locked=%0d step_err=%0d dir_change=%0d wrap=%0d err_cnt=%0d",
                 $time, dir, locked, step_err, dir_change, wrap, err_cnt);
        expect_out("reset2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b1;

        // After reset the first sample only seeds; then reacquire downward.
        sample(4'd9, 1'b1); expect_out("seed9",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        sample(4'd8, 1'b1); expect_out("acq8",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        sample(4'd7, 1'b1); expect_out("lock7",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
